// File: rtl/async_fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_stream_if
//
// Purpose:
//   Bundles the FIFO read port and the outgoing valid/ready stream of the
//   read-side drain engine into one interface.
//
// Signals:
//   fifo_rd_en      read strobe into the FIFO (engine -> FIFO)
//   fifo_rd_data    FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty      FIFO empty flag, already in the read clock domain
//   fifo_underflow  FIFO underflow pulse
//   m_valid/m_data/m_last/m_ready   outgoing burst-framed stream
//   err_underflow   sticky underflow flag
//   beat_count      total accepted beats (zero when statistics are disabled)
//
// Modports:
//   master  the drain engine (drives the FIFO strobe and the stream)
//   slave   the surroundings (FIFO model and downstream sink)
// -----------------------------------------------------------------------------
interface async_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  err_underflow;
    logic [31:0]           beat_count;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        input  fifo_underflow,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready,
        output err_underflow,
        output beat_count
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        output fifo_underflow,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready,
        input  err_underflow,
        input  beat_count
    );
endinterface

// File: rtl/async_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_stream
//
// Purpose:
//   Read-side drain engine for async_fifo_top, living entirely in rd_clk.
//   Issues read strobes into the FIFO read port (1-cycle read latency), lands
//   the returned words in a 2-entry skid buffer, presents them as a
//   valid/ready stream, frames that stream into bursts of BURST_LEN beats with
//   m_last, and keeps a sticky FIFO-underflow flag.
//
// Ports:
//   rd_clk   read-domain clock
//   rd_rst   synchronous, active-high reset
//   bus      async_fifo_rd_stream_if.master: FIFO read port (fifo_rd_en,
//            fifo_rd_data, fifo_empty, fifo_underflow), stream (m_valid,
//            m_data, m_last, m_ready), err_underflow, beat_count
//
// Parameters:
//   DATA_WIDTH  data width (must match the interface's DATA_WIDTH)
//   BURST_LEN   beats per burst, >= 1
//   BEAT_W      width of the beat index
//
// Configuration macro:
//   FIFO_RD_STATS_EN  when defined, beat_count counts accepted beats (wrapping
//                     at 2^32); otherwise beat_count is tied to zero.
// -----------------------------------------------------------------------------
module async_fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int BEAT_W     = $clog2(BURST_LEN + 1)
) (
    input logic                    rd_clk,
    input logic                    rd_rst,
    async_fifo_rd_stream_if.master bus
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(BURST_LEN - 1);

    occ_e                  occ_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [BEAT_W-1:0]     beat_idx_q;
    logic [BEAT_W-1:0]     beat_idx_d;
    logic                  err_q;

    logic                  push;
    logic                  pop;
    logic                  m_valid;
    logic                  rd_en;
    logic [2:0]            credit_used;

    // A word requested last cycle is on fifo_rd_data now and lands at this edge.
    assign push    = inflight_q;
    assign m_valid = (occ_q != OCC_EMPTY);
    assign pop     = m_valid & bus.m_ready;

    // Count the slots that will be taken after this edge (buffered plus
    // in flight, minus the one leaving); a new read is only issued if a slot
    // is guaranteed to be free when its data arrives.
    assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en       = !rd_rst && !bus.fifo_empty && (credit_used < 3'd2);

    // Skid buffer occupancy FSM together with its two data entries.
    // The head entry always drives m_data, so the stream output is registered.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= rd_en;
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        occ_q  <= OCC_ONE;
                        head_q <= bus.fifo_rd_data;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        occ_q  <= OCC_TWO;
                        tail_q <= bus.fifo_rd_data;
                    end else if (push && pop) begin
                        head_q <= bus.fifo_rd_data;
                    end else if (pop) begin
                        occ_q  <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        // Second entry moves to the head; a word landing in
                        // the same cycle refills the tail.
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= bus.fifo_rd_data;
                        end else begin
                            occ_q  <= OCC_ONE;
                        end
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    // Beat index within the current burst.
    always_comb begin
        beat_idx_d = beat_idx_q;
        if (pop) begin
            beat_idx_d = (beat_idx_q == LAST_IDX) ? '0 : beat_idx_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            beat_idx_q <= '0;
        end else begin
            beat_idx_q <= beat_idx_d;
        end
    end

    // Sticky underflow flag; only reset clears it.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            err_q <= 1'b0;
        end else if (bus.fifo_underflow) begin
            err_q <= 1'b1;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] beat_count_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            beat_count_q <= 32'h0;
        end else if (pop) begin
            beat_count_q <= beat_count_q + 32'h1;
        end
    end

    assign bus.beat_count = beat_count_q;
`else
    assign bus.beat_count = 32'h0;
`endif

    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_valid       = m_valid;
    assign bus.m_data        = head_q;
    assign bus.m_last        = m_valid && (beat_idx_q == LAST_IDX);
    assign bus.err_underflow = err_q;

    // The credit rule must make a landing word into a full, stalled buffer
    // impossible.
    no_overfill_a: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !((occ_q == OCC_TWO) && push && !pop));

endmodule
